dog_extrema_detector: RTL
=========================

Name: dog_extrema_detector

Overview:
- Streaming 3x3x3 scale-space extremum detector; sits directly downstream of the octave/DoG stage.
- Consumes one packed vector per pixel strobe: DOG_N 128-biased DoG samples, layer 0 in the LSBs.
- Flags pixels in the middle DoG layers that are strict maxima or minima against all 26 neighbours and exceed a contrast threshold.
- Emits keypoint x/y/layer/type pulses to the SPI readback / keypoint collection logic.

Parameters:
- FRAME_W, 640, pixels per line.
- FRAME_H, 480, lines per frame.
- DOG_N, 4, DoG layers per pixel; must be >= 3.
- DATA_W, 9, bits per DoG sample; signed container holding a 128-biased value.
- THRESH, 4, minimum |sample-128| for a candidate centre.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  pixel strobe; din valid when high.
- sof  in  1  start of frame; sampled only with en; marks din as pixel (0,0).
- din  in  DOG_N*DATA_W  DoG samples; layer i at [i*DATA_W+:DATA_W].
- kp_valid  out  1  one-cycle keypoint pulse.
- kp_x  out  11  keypoint column.
- kp_y  out  11  keypoint row.
- kp_layer  out  $clog2(DOG_N)  DoG layer of keypoint, range 1..DOG_N-2.
- kp_type  out  1  1 = maximum, 0 = minimum.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset: kp_valid, kp_x, kp_y, kp_layer, kp_type, frame_done = 0; x/y counters = 0. Line-buffer and window contents are not cleared; border gating masks them.
- Coordinates: (x,y) is the position of the current en pixel.
  - Each en: x++. At x = FRAME_W-1: x wraps to 0, y++.
  - At (FRAME_W-1, FRAME_H-1): x and y go to 0 and frame_done pulses on the next cycle.
  - en with sof: that pixel is (0,0) regardless of the counters; counters continue from it.
- Storage: two line buffers of FRAME_W x DOG_N*DATA_W, advanced only on en. Every layer also has a 3x3 window register: column shift on en, fed from the two line-buffer reads plus din.
- No en: no state change; outputs keep their values, except kp_valid and frame_done, which return to 0.
- Evaluation window:
  - Only when the incoming pixel has x >= 2 and y >= 2.
  - The window centre is then (x-1, y-1).
  - Centres on row 0, row FRAME_H-1, column 0 or column FRAME_W-1 are never evaluated.
- Candidate test for each middle layer L in 1..DOG_N-2:
  - c = centre of layer L.
  - Maximum: c > all 8 in-layer neighbours and c > all 9 samples of each of layers L-1 and L+1, i.e. strictly greater than all 26.
  - Minimum: c < all 26.
  - Contrast: |c-128| >= THRESH, computed signed in DATA_W+1 bits.
  - Ties never qualify.
- Several qualifying layers: report the lowest L only.
- Latency: kp_valid is registered, asserted the cycle after the en that completes the window. kp_x = x-1 and kp_y = y-1 of that pixel; kp_x/kp_y/kp_layer/kp_type update only when kp_valid asserts.
- Mid-frame rst: counters restart at 0; no keypoint is reported until two new rows have arrived.
- Mid-frame sof: same restart without touching outputs; frame_done does not pulse for the aborted frame.

Optional Feature:
- Macro DOG_KP_COUNT_EN.
- Defined: adds output kp_count (16 bits). An internal counter increments on each kp_valid and saturates at 16'hFFFF. Its value is copied to kp_count on the frame_done cycle, then the counter clears; if kp_valid coincides, that keypoint counts into the new frame. kp_count resets to 0 on rst.
- Undefined: no port, no counter.

Test Plan (all scenarios use FRAME_W=8, FRAME_H=6, DOG_N=4, THRESH=4, en every cycle):
- Flat 128 on all layers for 48 pixels, sof on first -> kp_valid never high; frame_done exactly once, the cycle after the 48th en.
- Layer 1 at (3,2) = 140, all else 128 -> single kp_valid the cycle after pixel (4,3); kp_x=3, kp_y=2, kp_layer=1, kp_type=1. With DOG_KP_COUNT_EN: kp_count=1 after frame_done.
- Layer 2 at (5,3) = 110, all else 128 -> kp_x=5, kp_y=3, kp_layer=2, kp_type=0.
- Layer 1 (3,2) = 140 and layer 0 (3,2) = 140 (tie) -> no kp_valid. Separately, layer 1 (3,2) = 131 -> below threshold, no kp_valid.
- Peak 140 at (0,2), (7,4), (3,0) and (3,5) in turn -> no kp_valid for any.
- rst asserted after pixel (2,3), then new frame with the same peak as scenario 2 -> exactly one keypoint at (3,2), no spurious pulse from stale line data.

Source files
------------

// File: rtl/dog_extrema_detector.sv
// Streaming 3x3x3 DoG scale-space extremum detector with raster x/y tracking.
// Optional DOG_KP_COUNT_EN adds a per-frame keypoint count output (kp_count).
module dog_extrema_detector #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int DOG_N   = 4,
    parameter int DATA_W  = 9,
    parameter int THRESH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sof,
    input  logic [DOG_N*DATA_W-1:0]    din,
    output logic                       kp_valid,
    output logic [10:0]                kp_x,
    output logic [10:0]                kp_y,
    output logic [$clog2(DOG_N)-1:0]   kp_layer,
    output logic                       kp_type,
    output logic                       frame_done
`ifdef DOG_KP_COUNT_EN
    ,
    output logic [15:0]                kp_count
`endif
);

    localparam int PW = DOG_N * DATA_W;
    localparam int LW = $clog2(DOG_N);
    localparam int AW = $clog2(FRAME_W);
    localparam logic [10:0] XMAX = 11'(FRAME_W - 1);
    localparam logic [10:0] YMAX = 11'(FRAME_H - 1);
    localparam logic signed [DATA_W:0] TH_P = (DATA_W+1)'(THRESH);
    localparam logic signed [DATA_W:0] TH_N = -TH_P;
    localparam logic signed [DATA_W:0] BIAS = (DATA_W+1)'(128);

    typedef logic signed [DATA_W-1:0] samp_t;

    function automatic samp_t samp(input logic [PW-1:0] v, input int l);
        return samp_t'(v[l*DATA_W +: DATA_W]);
    endfunction

    logic [10:0]   x_q, y_q, x_cur, y_cur, x_d, y_d;
    logic          last_pix;
    logic [AW-1:0] addr;

    // sof forces the current pixel to (0,0) regardless of the counters
    assign x_cur = sof ? 11'd0 : x_q;
    assign y_cur = sof ? 11'd0 : y_q;
    assign addr  = x_cur[AW-1:0];

    always_comb begin
        x_d      = x_cur + 11'd1;
        y_d      = y_cur;
        last_pix = 1'b0;
        if (x_cur == XMAX) begin
            x_d = 11'd0;
            if (y_cur == YMAX) begin
                y_d      = 11'd0;
                last_pix = 1'b1;
            end else begin
                y_d = y_cur + 11'd1;
            end
        end
    end

    logic [PW-1:0] lb0 [FRAME_W];
    logic [PW-1:0] lb1 [FRAME_W];
    logic [2:0][1:0][PW-1:0] win_q;
    logic [2:0][PW-1:0]      col_new;
    logic [2:0][2:0][PW-1:0] win;

    // row 0 = two lines up, row 1 = previous line, row 2 = incoming line
    assign col_new[0] = lb1[addr];
    assign col_new[1] = lb0[addr];
    assign col_new[2] = din;

    always_ff @(posedge clk) begin
        if (en) begin
            lb0[addr] <= din;
            lb1[addr] <= lb0[addr];
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= col_new[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win[r][0] = win_q[r][0];
            win[r][1] = win_q[r][1];
            win[r][2] = col_new[r];
        end
    end

    logic          hit, hit_t;
    logic [LW-1:0] hit_l;

    always_comb begin
        hit   = 1'b0;
        hit_t = 1'b0;
        hit_l = '0;
        for (int L = 1; L <= DOG_N - 2; L++) begin
            samp_t                   ctr;
            samp_t                   s;
            logic                    gt;
            logic                    lt;
            logic signed [DATA_W:0]  diff;
            ctr  = samp(win[1][1], L);
            s    = '0;
            gt   = 1'b1;
            lt   = 1'b1;
            for (int dl = -1; dl <= 1; dl++) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        if (!(dl == 0 && r == 1 && c == 1)) begin
                            s = samp(win[r][c], L + dl);
                            if (!(ctr > s)) gt = 1'b0;
                            if (!(ctr < s)) lt = 1'b0;
                        end
                    end
                end
            end
            diff = $signed({ctr[DATA_W-1], ctr}) - BIAS;
            // lowest qualifying layer wins
            if (!hit && (gt || lt) && (diff >= TH_P || diff <= TH_N)) begin
                hit   = 1'b1;
                hit_t = gt;
                hit_l = LW'(L);
            end
        end
    end

    logic          eval_ok;
    logic          kp_valid_q, kp_type_q, frame_done_q;
    logic [10:0]   kp_x_q, kp_y_q;
    logic [LW-1:0] kp_layer_q;

    assign eval_ok = (x_cur >= 11'd2) && (y_cur >= 11'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            kp_valid_q   <= 1'b0;
            kp_x_q       <= '0;
            kp_y_q       <= '0;
            kp_layer_q   <= '0;
            kp_type_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            kp_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            if (en) begin
                x_q          <= x_d;
                y_q          <= y_d;
                frame_done_q <= last_pix;
                if (eval_ok && hit) begin
                    kp_valid_q <= 1'b1;
                    kp_x_q     <= x_cur - 11'd1;
                    kp_y_q     <= y_cur - 11'd1;
                    kp_layer_q <= hit_l;
                    kp_type_q  <= hit_t;
                end
            end
        end
    end

    assign kp_valid   = kp_valid_q;
    assign kp_x       = kp_x_q;
    assign kp_y       = kp_y_q;
    assign kp_layer   = kp_layer_q;
    assign kp_type    = kp_type_q;
    assign frame_done = frame_done_q;

`ifdef DOG_KP_COUNT_EN
    logic [15:0] cnt_q, kp_count_q;

    // a keypoint landing on the frame_done cycle is charged to the new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            kp_count_q <= '0;
        end else if (frame_done_q) begin
            kp_count_q <= cnt_q;
            cnt_q      <= {15'd0, kp_valid_q};
        end else if (kp_valid_q && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign kp_count = kp_count_q;
`endif

endmodule
